// File: rtl/mnist_pkg.sv
// mnist_pkg: shared FSM encoding, status codes and abort result code for the MNIST frame controller
package mnist_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT_RES,
    ST_SEND_RES,
    ST_SEND_STAT
  } state_t;
  typedef enum logic [1:0] {
    PH_REQ,
    PH_RISE,
    PH_FALL
  } tx_ph_t;
  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_RX_TMO  = 8'h01;
  localparam logic [7:0] STAT_RES_TMO = 8'h02;
  localparam logic [7:0] RES_ABORT    = 8'hFF;
endpackage

// File: rtl/mnist_tmo_cnt.sv
// mnist_tmo_cnt: saturating timeout counter, terminal count once LIMIT cycles have elapsed since clear
module mnist_tmo_cnt #(
  parameter int LIMIT = 1000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(LIMIT);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mnist_frame_ctrl.sv
// mnist_frame_ctrl: UART frame receiver feeding the network core, reporting result and status bytes back over UART
module mnist_frame_ctrl
  import mnist_pkg::*;
#(
  parameter int         FRAME_LEN = 784,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         RX_TMO    = 5_000_000,
  parameter int         RES_TMO   = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  px_data,
  output logic        px_valid,
  output logic        core_clr,
  input  logic [31:0] core_result,
  input  logic        core_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [3:0]  disp_num,
  output logic [7:0]  err_cnt
);
  localparam int PW = $clog2(FRAME_LEN + 1);
  state_t       state, state_n;
  tx_ph_t       ph, ph_n;
  logic [PW-1:0] px_cnt;
  logic [7:0]   res_byte, stat_byte;
  logic         rx_tc, res_tc;
  logic         sync, px_take, rx_abort, res_ok, res_abort, sending;
  logic         unused_hi;
  assign unused_hi = ^core_result[31:8];
  assign sync      = state == ST_IDLE && rx_valid && rx_byte == SYNC_BYTE;
  assign px_take   = state == ST_RECV && rx_valid && !rx_tc;
  assign rx_abort  = state == ST_RECV && rx_tc;
  assign res_ok    = state == ST_WAIT_RES && core_valid;
  assign res_abort = state == ST_WAIT_RES && res_tc && !core_valid;
  assign sending   = state == ST_SEND_RES || state == ST_SEND_STAT;
  // tx_start is combinational so it can never coincide with tx_busy
  assign tx_start  = sending && ph == PH_REQ && !tx_busy;
  assign tx_data   = state == ST_SEND_STAT ? stat_byte : state == ST_SEND_RES ? res_byte : 8'h00;
  mnist_tmo_cnt #(.LIMIT(RX_TMO)) u_rx_tmo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (state != ST_RECV || rx_valid),
    .en       (state == ST_RECV),
    .tc       (rx_tc)
  );
  mnist_tmo_cnt #(.LIMIT(RES_TMO)) u_res_tmo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (state != ST_WAIT_RES),
    .en       (state == ST_WAIT_RES),
    .tc       (res_tc)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      ph    <= PH_REQ;
    end else begin
      state <= state_n;
      ph    <= ph_n;
    end
  always_comb begin
    state_n = state;
    ph_n    = ph;
    case (state)
      ST_IDLE:     state_n = sync ? ST_RECV : ST_IDLE;
      ST_RECV: begin
        if (rx_abort) begin
          state_n = ST_SEND_RES;
          ph_n    = PH_REQ;
        end else if (px_take && px_cnt == PW'(FRAME_LEN - 1)) state_n = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (res_ok || res_abort) begin
          state_n = ST_SEND_RES;
          ph_n    = PH_REQ;
        end
      end
      ST_SEND_RES, ST_SEND_STAT: begin
        case (ph)
          PH_REQ:  ph_n = tx_start ? PH_RISE : PH_REQ;
          PH_RISE: ph_n = tx_busy ? PH_FALL : PH_RISE;
          default: begin
            if (!tx_busy) begin
              ph_n    = PH_REQ;
              state_n = state == ST_SEND_RES ? ST_SEND_STAT : ST_IDLE;
            end
          end
        endcase
      end
      default: begin
        state_n = ST_IDLE;
        ph_n    = PH_REQ;
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      px_valid  <= 1'b0;
      px_data   <= 8'h00;
      core_clr  <= 1'b0;
      px_cnt    <= '0;
      res_byte  <= 8'h00;
      stat_byte <= 8'h00;
      disp_num  <= 4'h0;
      err_cnt   <= 8'h00;
    end else begin
      px_valid <= px_take;
      core_clr <= rx_abort || res_abort;
      if (px_take) px_data <= rx_byte;
      if (sync) px_cnt <= '0;
      else if (px_take) px_cnt <= px_cnt + 1'b1;
      if (res_ok) begin
        res_byte  <= core_result[7:0];
        stat_byte <= STAT_OK;
        disp_num  <= core_result[3:0];
      end
      if (rx_abort || res_abort) begin
        res_byte  <= RES_ABORT;
        stat_byte <= rx_abort ? STAT_RX_TMO : STAT_RES_TMO;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// tb_mnist_frame_ctrl: randomized frame traffic against a queue-based model of forwarded pixels and UART bytes
module tb_mnist_frame_ctrl;
  localparam int         FL  = 784;
  localparam logic [7:0] SB  = 8'hAA;
  localparam int         RXT = 500;
  localparam int         RST = 800;
  logic        sys_clk = 0, sys_rst_n = 0;
  logic [7:0]  rx_byte = 0;
  logic        rx_valid = 0;
  logic [7:0]  px_data;
  logic        px_valid, core_clr, tx_start, tx_busy;
  logic [31:0] core_result = 0;
  logic        core_valid = 0;
  logic [7:0]  tx_data, err_cnt;
  logic [3:0]  disp_num;
  logic        hold_busy = 0, ubusy = 0;
  int          ucnt = 0;
  int          errors = 0, checks = 0, viol = 0, clr_n = 0;
  logic [7:0]  pxq[$], txq[$], exp_px[$];
  logic [7:0]  exp_err = 0;
  logic [3:0]  exp_disp = 0;
  assign tx_busy = ubusy | hold_busy;
  always #10 sys_clk = ~sys_clk;
  mnist_frame_ctrl #(.FRAME_LEN(FL), .SYNC_BYTE(SB), .RX_TMO(RXT), .RES_TMO(RST)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .px_data(px_data), .px_valid(px_valid), .core_clr(core_clr), .core_result(core_result),
    .core_valid(core_valid), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .disp_num(disp_num), .err_cnt(err_cnt)
  );
  always @(posedge sys_clk)
    if (tx_start && !ubusy) begin
      txq.push_back(tx_data);
      ubusy <= 1;
      ucnt  <= 6;
    end else if (ubusy) begin
      if (ucnt == 0) ubusy <= 0;
      else ucnt <= ucnt - 1;
    end
  always @(negedge sys_clk) begin
    if (px_valid) pxq.push_back(px_data);
    if (core_clr) clr_n++;
    if (tx_start && tx_busy) viol++;
  end
  function automatic bit px_match();
    if (pxq.size() != exp_px.size()) return 0;
    foreach (pxq[i]) if (pxq[i] !== exp_px[i]) return 0;
    return 1;
  endfunction
  task automatic clear();
    pxq.delete();
    txq.delete();
    exp_px.delete();
    clr_n = 0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1;
    @(negedge sys_clk);
    rx_valid = 0;
    repeat (gap) @(negedge sys_clk);
  endtask
  task automatic send_pixels(input int n, input int maxgap);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (i % 97 == 5) ? SB : 8'($urandom);
      exp_px.push_back(b);
      send(b, $urandom_range(maxgap, 0));
    end
  endtask
  task automatic pulse_core(input logic [31:0] r);
    core_result = r;
    core_valid  = 1;
    @(negedge sys_clk);
    core_valid = 0;
  endtask
  task automatic wait_tx(input int budget, input string name);
    int k = 0;
    while (txq.size() < 2 && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    checks++;
    if (txq.size() < 2) begin
      errors++;
      $display("FAIL %s_tx_wait: got %0d bytes, required 2", name, txq.size());
    end
    repeat (20) @(negedge sys_clk);
  endtask
  task automatic test_reset();
    sys_rst_n = 0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({px_valid, tx_start, core_clr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 000", {px_valid, tx_start, core_clr});
    end
    checks++;
    if ({px_data, tx_data, disp_num, err_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {px_data, tx_data, disp_num, err_cnt});
    end
    sys_rst_n = 1;
    @(negedge sys_clk);
  endtask
  task automatic test_ignore_core();
    clear();
    pulse_core(32'h0000_0003);
    send(8'h33, 2);
    repeat (30) @(negedge sys_clk);
    checks++;
    if (txq.size() != 0 || pxq.size() != 0 || disp_num !== exp_disp) begin
      errors++;
      $display("FAIL ignore_idle: tx=%0d px=%0d disp=%0d, required 0 0 %0d", txq.size(), pxq.size(), disp_num, exp_disp);
    end
  endtask
  task automatic test_frame(input logic [31:0] r, input bit pre, input int maxgap, input string name);
    clear();
    if (pre) begin
      send(8'h55, 2);
      send(8'h12, 1);
      for (int i = 0; i < 5; i++) send(8'($urandom_range(8'hA9, 0)), 1);
    end
    send(SB, 1);
    send_pixels(FL, maxgap);
    for (int i = 0; i < 3; i++) send(8'($urandom), 2);
    pulse_core(r);
    exp_disp = r[3:0];
    wait_tx(200, name);
    checks++;
    if (!px_match()) begin
      errors++;
      $display("FAIL %s_pixels: got %0d pixels, required %0d matching", name, pxq.size(), exp_px.size());
    end
    checks++;
    if (txq.size() != 2 || txq[0] !== r[7:0] || txq[1] !== 8'h00) begin
      errors++;
      $display("FAIL %s_tx: got %0d bytes first %h, required %h 00", name, txq.size(), txq.size() ? txq[0] : 8'hxx, r[7:0]);
    end
    checks++;
    if (disp_num !== exp_disp || err_cnt !== exp_err || clr_n != 0) begin
      errors++;
      $display("FAIL %s_status: disp=%0d err=%0d clr=%0d, required %0d %0d 0", name, disp_num, err_cnt, clr_n, exp_disp, exp_err);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] b;
    clear();
    send(SB, 0);
    b = 8'($urandom);
    exp_px.push_back(b);
    rx_byte  = b;
    rx_valid = 1;
    @(negedge sys_clk);
    checks++;
    if (px_valid !== 1'b1 || px_data !== b) begin
      errors++;
      $display("FAIL latency: px_valid=%b px_data=%h, required 1 %h", px_valid, px_data, b);
    end
    rx_valid = 0;
    send_pixels(FL - 1, 0);
    pulse_core(32'hDEAD_BE5C);
    exp_disp = 4'hC;
    wait_tx(200, "b2b");
    checks++;
    if (!px_match() || txq.size() != 2 || txq[0] !== 8'h5C || txq[1] !== 8'h00 || disp_num !== exp_disp) begin
      errors++;
      $display("FAIL b2b: px=%0d tx=%0d disp=%0d, required %0d 2 %0d", pxq.size(), txq.size(), disp_num, FL, exp_disp);
    end
  endtask
  task automatic test_rx_timeout();
    clear();
    send(SB, 1);
    send_pixels(100, 3);
    exp_err++;
    wait_tx(RXT + 100, "rx_tmo");
    checks++;
    if (txq.size() != 2 || txq[0] !== 8'hFF || txq[1] !== 8'h01) begin
      errors++;
      $display("FAIL rx_tmo_tx: got %0d bytes first %h, required FF 01", txq.size(), txq.size() ? txq[0] : 8'hxx);
    end
    checks++;
    if (clr_n != 1 || err_cnt !== exp_err || disp_num !== exp_disp || !px_match()) begin
      errors++;
      $display("FAIL rx_tmo_status: clr=%0d err=%0d disp=%0d px=%0d, required 1 %0d %0d 100", clr_n, err_cnt, disp_num, pxq.size(), exp_err, exp_disp);
    end
  endtask
  task automatic test_res_timeout();
    clear();
    send(SB, 1);
    send_pixels(FL, 2);
    exp_err++;
    wait_tx(RST + 100, "res_tmo");
    checks++;
    if (txq.size() != 2 || txq[0] !== 8'hFF || txq[1] !== 8'h02) begin
      errors++;
      $display("FAIL res_tmo_tx: got %0d bytes first %h, required FF 02", txq.size(), txq.size() ? txq[0] : 8'hxx);
    end
    checks++;
    if (clr_n != 1 || err_cnt !== exp_err || disp_num !== exp_disp) begin
      errors++;
      $display("FAIL res_tmo_status: clr=%0d err=%0d disp=%0d, required 1 %0d %0d", clr_n, err_cnt, disp_num, exp_err, exp_disp);
    end
  endtask
  task automatic test_busy_hold();
    logic [31:0] r;
    clear();
    r = $urandom;
    send(SB, 1);
    send_pixels(FL, 2);
    hold_busy = 1;
    pulse_core(r);
    exp_disp = r[3:0];
    repeat (2000) @(negedge sys_clk);
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL busy_hold: got %0d bytes while busy, required 0", txq.size());
    end
    hold_busy = 0;
    wait_tx(200, "busy");
    checks++;
    if (txq.size() != 2 || txq[0] !== r[7:0] || txq[1] !== 8'h00 || disp_num !== exp_disp) begin
      errors++;
      $display("FAIL busy_order: got %0d bytes first %h, required %h 00", txq.size(), txq.size() ? txq[0] : 8'hxx, r[7:0]);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL start_while_busy: got %0d events, required 0", viol);
    end
  endtask
  task automatic test_reset_mid();
    clear();
    send(SB, 1);
    send_pixels(400, 2);
    sys_rst_n = 0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    exp_err  = 0;
    exp_disp = 0;
    repeat (RST + RXT + 100) @(negedge sys_clk);
    checks++;
    if (txq.size() != 0 || clr_n != 0 || err_cnt !== exp_err || disp_num !== exp_disp) begin
      errors++;
      $display("FAIL reset_mid: tx=%0d clr=%0d err=%0d disp=%0d, required 0 0 0 0", txq.size(), clr_n, err_cnt, disp_num);
    end
  endtask
  initial begin
    @(negedge sys_clk);
    test_reset();
    test_ignore_core();
    test_frame(32'h0000_0007, 1, 3, "frame7");
    test_back_to_back();
    test_rx_timeout();
    test_res_timeout();
    test_busy_hold();
    test_reset_mid();
    test_frame($urandom, 0, 3, "frame_after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
